// File: rtl/mod_ctrl_pkg.sv
// Shared definitions for the modulo controller: state encoding, default
// iteration cap and the quotient-counter width helper.
package mod_ctrl_pkg;

    // 2-bit binary state encoding, also used by the ALU top
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int MAX_ITER_DEF = 1024;

    // Counter must hold the value MAX_ITER itself, hence the +1
    function automatic int cnt_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/mod_ctrl_if.sv
// Control/status bundle between the modulo controller, its datapath and the
// ALU top. The master side drives start, B and comp; the controller is the slave.
interface mod_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 11
);
    logic             start;
    logic [WIDTH-1:0] B;
    logic             comp;
    logic             ld_temp;
    logic             sub;
    logic             busy;
    logic             done;
    logic             err_div0;
    logic             ovf;
    logic [CNT_W-1:0] quotient;

    modport master (
        output start, B, comp,
        input  ld_temp, sub, busy, done, err_div0, ovf, quotient
    );

    modport slave (
        input  start, B, comp,
        output ld_temp, sub, busy, done, err_div0, ovf, quotient
    );
endinterface

// File: rtl/mod_ctrl.sv
// Sequencer for the repeated-subtraction modulo datapath. Loads TEMP, issues
// subtract strobes while TEMP >= B, counts them as the quotient, and flags
// divide-by-zero and runaway (MAX_ITER reached with comp still set).
//
// state | meaning
// IDLE  | waiting for start; results of the last operation held
// LOAD  | ld_temp strobe, TEMP <= A
// RUN   | sub strobe while comp and below the cap; quotient counts
// DONE  | one-cycle done pulse, results valid
module mod_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mod_ctrl_if.slave      bus
);

    localparam int               CNT_W    = cnt_width(MAX_ITER);
    localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(MAX_ITER);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] quotient_q, quotient_d;
    logic             err_div0_q, err_div0_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_val;
    logic             b_zero;
    logic             sub_w;

    assign b_val  = bus.B;
    assign b_zero = (b_val == '0);

    // Cap is checked before incrementing, so the counter can never wrap
    assign sub_w = (state_q == RUN) && bus.comp && (quotient_q != ITER_CAP);

    // Next-state and result register updates
    always_comb begin
        state_d    = state_q;
        quotient_d = quotient_q;
        err_div0_d = err_div0_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quotient_d = '0;
                    ovf_d      = 1'b0;
                    if (b_zero) begin
                        err_div0_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        err_div0_d = 1'b0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (sub_w) begin
                    quotient_d = quotient_q + CNT_W'(1);
                end else if (!bus.comp) begin
                    state_d = DONE;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            quotient_q <= '0;
            err_div0_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            quotient_q <= quotient_d;
            err_div0_q <= err_div0_d;
            ovf_q      <= ovf_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign bus.ld_temp  = (state_q == LOAD);
    assign bus.sub      = sub_w;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.err_div0 = err_div0_q;
    assign bus.ovf      = ovf_q;
    assign bus.quotient = quotient_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// Bench for mod_ctrl: a behavioural datapath supplies comp, and each operation
// is checked cycle by cycle against the timeline and results predicted from A/B.
module tb_mod_ctrl;
    import mod_ctrl_pkg::*;

    localparam int MAX = 4;
    localparam int CW  = cnt_width(MAX);

    logic        clk;
    logic        reset;
    logic [31:0] dp_a;
    logic [31:0] temp;

    int checks   = 0;
    int failures = 0;

    mod_ctrl_if #(.WIDTH(32), .CNT_W(CW)) bus ();

    mod_ctrl #(.WIDTH(32), .MAX_ITER(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           temp <= '0;
        else if (bus.ld_temp) temp <= dp_a;
        else if (bus.sub)     temp <= temp - bus.B;
    end
    assign bus.comp = (temp >= bus.B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld"},   32'(bus.ld_temp),  0);
        chk({tag, "_sub"},  32'(bus.sub),      0);
        chk({tag, "_busy"}, 32'(bus.busy),     0);
        chk({tag, "_done"}, 32'(bus.done),     0);
        chk({tag, "_div0"}, 32'(bus.err_div0), 0);
        chk({tag, "_ovf"},  32'(bus.ovf),      0);
        chk({tag, "_q"},    32'(bus.quotient), 0);
    endtask

    // restart_k: cycle after acceptance in which start is pulsed again (0 none,
    // -1 the done cycle). reset_k: cycle in which reset is asserted (0 none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int restart_k, input int reset_k);
        int q_full, q_exp, last, rk;
        logic ovf_exp, div0;
        div0    = (b == 0);
        q_full  = div0 ? 0 : int'(a / b);
        q_exp   = (q_full > MAX) ? MAX : q_full;
        ovf_exp = !div0 && (q_full > MAX);
        last    = div0 ? 1 : q_exp + 3;
        rk      = (restart_k < 0) ? last : restart_k;

        @(negedge clk);
        dp_a      = a;
        bus.B     = b;
        bus.start = 1'b1;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            chk("ld_temp", 32'(bus.ld_temp), 32'(!div0 && k == 1));
            chk("sub",     32'(bus.sub),     32'(!div0 && k >= 2 && k <= q_exp + 1));
            chk("done",    32'(bus.done),    32'(k == last));
            chk("busy",    32'(bus.busy),    32'(k <= last));
            if (k >= last) begin
                chk("quotient", 32'(bus.quotient), 32'(q_exp));
                chk("err_div0", 32'(bus.err_div0), 32'(div0));
                chk("ovf",      32'(bus.ovf),      32'(ovf_exp));
                if (!div0) chk("temp", temp, a - 32'(q_exp) * b);
            end
            if (k == 1)      bus.start = 1'b0;
            if (k == rk)     bus.start = 1'b1;
            if (k == rk + 1) bus.start = 1'b0;
            if (k == reset_k) begin
                reset = 1'b0;
                #1;
                chk_all_zero("async_rst");
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("rst_no_done", 32'(bus.done), 0);
                    chk("rst_no_busy", 32'(bus.busy), 0);
                end
                reset     = 1'b1;
                bus.start = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.B     = '0;
        dp_a      = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        run_op(32'd17,  32'd5, 0, 0);   // nominal
        run_op(32'd4,   32'd9, 0, 0);   // A < B
        run_op(32'd17,  32'd0, 0, 0);   // divide by zero
        run_op(32'd100, 32'd1, 0, 0);   // overflow
        run_op(32'd20,  32'd5, 0, 0);   // quotient exactly at cap, no overflow
        run_op(32'd17,  32'd5, 3, 0);   // start during RUN ignored
        run_op(32'd17,  32'd5, 1, 0);   // start during LOAD ignored
        run_op(32'd17,  32'd5, -1, 0);  // start during DONE ignored
        run_op(32'd17,  32'd5, 0, 0);   // fresh run after the above
        run_op(32'd7,   32'd0, -1, 0);  // div0 with start in DONE
        run_op(32'd17,  32'd5, 0, 3);   // reset mid-RUN
        run_op(32'd17,  32'd5, 0, 0);   // normal after reset

        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = 32'($urandom_range(0, 40));
            rb = 32'($urandom_range(0, 7));
            run_op(ra, rb, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
